enc_param_ctrl: RTL and testbench

Parameter-editing controller driven by the rotary-encoder and pushbutton front end of `tt_um_csit_luks`. It consumes decoded detent steps and classified button presses. A two-state browse/edit machine uses them to select one of `NUM_PARAMS` registers and edit its value. The block also publishes all parameter values and a one-cycle update strobe for downstream consumers.

---
 rtl/enc_param_ctrl.sv | 137 +++++++++++++
 tb/tb_enc_param_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/enc_param_ctrl.sv
// Browse/edit controller for encoder-driven parameter registers.
// Publishes the register file and a one-cycle update strobe on every value change.
//
// state  | meaning
// BROWSE | encoder steps move sel; short press enters EDIT; long press zeroes params[sel]
// EDIT   | encoder steps edit params[sel]; short press or timeout commits; long press restores backup
module enc_param_ctrl #(
  parameter int NUM_PARAMS = 4,
  parameter int PARAM_W = 8,
  parameter int TIMEOUT_CYC = 1000000,
  localparam int SW = (NUM_PARAMS > 2) ? $clog2(NUM_PARAMS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          step_valid,
  input  logic                          step_cw,
  input  logic                          press_valid,
  input  logic                          press_long,
  output logic [SW-1:0]                 sel,
  output logic                          editing,
  output logic [NUM_PARAMS*PARAM_W-1:0] params,
  output logic                          upd_valid,
  output logic [SW-1:0]                 upd_idx
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [SW-1:0] SEL_LAST = SW'(NUM_PARAMS - 1);
  localparam logic [PARAM_W-1:0] VAL_MAX = {PARAM_W{1'b1}};

  typedef enum logic [0:0] {
    BROWSE = 1'b0,
    EDIT   = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [SW-1:0]        sel_q, sel_d;
  logic [PARAM_W-1:0]   param_q [NUM_PARAMS];
  logic [PARAM_W-1:0]   param_d [NUM_PARAMS];
  logic [PARAM_W-1:0]   backup_q, backup_d;
  logic [CNT_W-1:0]     idle_q, idle_d;
  logic                 upd_valid_q, upd_valid_d;
  logic [SW-1:0]        upd_idx_q, upd_idx_d;
  logic [PARAM_W-1:0]   cur;

  assign cur = param_q[sel_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BROWSE;
      sel_q       <= '0;
      param_q     <= '{default: '0};
      backup_q    <= '0;
      idle_q      <= '0;
      upd_valid_q <= 1'b0;
      upd_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      param_q     <= param_d;
      backup_q    <= backup_d;
      idle_q      <= idle_d;
      upd_valid_q <= upd_valid_d;
      upd_idx_q   <= upd_idx_d;
    end
  end

  // A press always wins over a simultaneous step; the step is dropped.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    param_d     = param_q;
    backup_d    = backup_q;
    idle_d      = '0;
    upd_valid_d = 1'b0;
    upd_idx_d   = upd_idx_q;
    case (state_q)
      BROWSE: begin
        if (press_valid) begin
          if (press_long) begin
            param_d[sel_q] = '0;
            if (cur != '0) begin
              upd_valid_d = 1'b1;
              upd_idx_d   = sel_q;
            end
          end else begin
            state_d  = EDIT;
            backup_d = cur;
          end
        end else if (step_valid) begin
          if (step_cw) begin
            sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + SW'(1);
          end else begin
            sel_d = (sel_q == '0) ? SEL_LAST : sel_q - SW'(1);
          end
        end
      end
      EDIT: begin
        if (press_valid) begin
          state_d = BROWSE;
          if (press_long) begin
            param_d[sel_q] = backup_q;
            if (backup_q != cur) begin
              upd_valid_d = 1'b1;
              upd_idx_d   = sel_q;
            end
          end
        end else if (step_valid) begin
          if (step_cw && cur != VAL_MAX) begin
            param_d[sel_q] = cur + PARAM_W'(1);
            upd_valid_d    = 1'b1;
            upd_idx_d      = sel_q;
          end else if (!step_cw && cur != '0) begin
            param_d[sel_q] = cur - PARAM_W'(1);
            upd_valid_d    = 1'b1;
            upd_idx_d      = sel_q;
          end
        end else if (idle_q == IDLE_LAST) begin
          state_d = BROWSE;
        end else begin
          idle_d = idle_q + CNT_W'(1);
        end
      end
      default: state_d = BROWSE;
    endcase
  end

  for (genvar i = 0; i < NUM_PARAMS; i++) begin : g_flat
    assign params[i*PARAM_W +: PARAM_W] = param_q[i];
  end

  assign sel       = sel_q;
  assign editing   = (state_q == EDIT);
  assign upd_valid = upd_valid_q;
  assign upd_idx   = upd_idx_q;

endmodule

// File: tb/tb_enc_param_ctrl.sv
// Scoreboard bench for enc_param_ctrl: directed test-plan sequences plus random
// encoder/button traffic checked against a behavioural model of the editor.
module tb_enc_param_ctrl;

  localparam int NP = 4;
  localparam int PW = 8;
  localparam int TO = 16;
  localparam int SW = 2;
  localparam int VMAX = (1 << PW) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              step_valid = 1'b0, step_cw = 1'b0;
  logic              press_valid = 1'b0, press_long = 1'b0;
  logic [SW-1:0]     sel;
  logic              editing;
  logic [NP*PW-1:0]  params;
  logic              upd_valid;
  logic [SW-1:0]     upd_idx;

  enc_param_ctrl #(.NUM_PARAMS(NP), .PARAM_W(PW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .step_valid(step_valid), .step_cw(step_cw),
    .press_valid(press_valid), .press_long(press_long),
    .sel(sel), .editing(editing), .params(params),
    .upd_valid(upd_valid), .upd_idx(upd_idx)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; int val; } upd_t;
  upd_t sb[$];

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int last_idx = 0;

  // behavioural model of the user-visible state
  bit m_edit;
  int m_sel, m_backup, m_idle;
  int m_val [NP];

  function automatic void check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_edit = 0; m_sel = 0; m_backup = 0; m_idle = 0;
    for (int i = 0; i < NP; i++) m_val[i] = 0;
    sb.delete();
    last_idx = 0;
  endfunction

  function automatic void set_val(int v);
    upd_t u;
    if (v != m_val[m_sel]) begin
      u.idx = m_sel; u.val = v;
      sb.push_back(u);
    end
    m_val[m_sel] = v;
  endfunction

  function automatic void model_edge(bit sv, bit cw, bit pv, bit pl);
    if (!m_edit) begin
      if (pv) begin
        if (pl) set_val(0);
        else begin m_edit = 1; m_backup = m_val[m_sel]; m_idle = 0; end
      end else if (sv) begin
        m_sel = cw ? (m_sel + 1) % NP : (m_sel + NP - 1) % NP;
      end
    end else begin
      if (pv) begin
        m_edit = 0;
        if (pl) set_val(m_backup);
      end else if (sv) begin
        m_idle = 0;
        if (cw) set_val(m_val[m_sel] < VMAX ? m_val[m_sel] + 1 : VMAX);
        else    set_val(m_val[m_sel] > 0 ? m_val[m_sel] - 1 : 0);
      end else begin
        m_idle++;
        if (m_idle == TO) m_edit = 0;
      end
    end
  endfunction

  task automatic cycle(bit sv, bit cw, bit pv, bit pl);
    step_valid = sv; step_cw = cw; press_valid = pv; press_long = pl;
    @(posedge clk);
    model_edge(sv, cw, pv, pl);
    @(negedge clk);
    step_valid = 0; step_cw = 0; press_valid = 0; press_long = 0;
    #1;
    check("sel", int'(sel), m_sel);
    check("editing", int'(editing), int'(m_edit));
    for (int i = 0; i < NP; i++) check($sformatf("param%0d", i), int'(params[i*PW +: PW]), m_val[i]);
    check("missed_upd", sb.size(), 0);
  endtask

  task automatic step(bit cw);  cycle(1, cw, 0, 0); endtask
  task automatic press(bit lg); cycle(0, 0, 1, lg); endtask
  task automatic idle(int n);   for (int k = 0; k < n; k++) cycle(0, 0, 0, 0); endtask

  task automatic goto_sel(int s);
    for (int k = 0; k < NP && int'(sel) != s; k++) step(1);
  endtask

  // monitor: pops one expectation per strobe and checks upd_idx holds otherwise
  initial begin
    upd_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (upd_valid) begin
          pulses++;
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL upd_unexpected actual_idx=%0d required=no_pulse", upd_idx);
          end else begin
            e = sb.pop_front();
            check("upd_idx", int'(upd_idx), e.idx);
            check("upd_val", int'(params[e.idx*PW +: PW]), e.val);
            last_idx = e.idx;
          end
        end else begin
          check("upd_idx_hold", int'(upd_idx), last_idx);
        end
      end
    end
  end

  initial begin
    int p0, n;
    model_reset();
    // reset state
    #2;
    check("rst_sel", int'(sel), 0);
    check("rst_editing", int'(editing), 0);
    check("rst_params", (params == '0) ? 1 : 0, 1);
    check("rst_upd_valid", int'(upd_valid), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    idle(20);

    // selection wrap
    p0 = pulses;
    for (int k = 0; k < 5; k++) step(1);
    check("wrap_cw_sel", int'(sel), 1);
    step(0); step(0);
    check("wrap_ccw_sel", int'(sel), 3);
    check("wrap_no_pulse", pulses - p0, 0);

    // edit and saturation on register 2
    goto_sel(2);
    press(0);
    check("edit_entry", int'(editing), 1);
    p0 = pulses;
    for (int k = 0; k < 3; k++) step(1);
    check("edit_val3", int'(params[2*PW +: PW]), 3);
    check("edit_pulses3", pulses - p0, 3);
    check("edit_idx", int'(upd_idx), 2);
    p0 = pulses;
    for (int k = 0; k < 5; k++) step(0);
    check("edit_val0", int'(params[2*PW +: PW]), 0);
    check("edit_pulses_down", pulses - p0, 3);
    for (int k = 0; k < VMAX; k++) step(1);
    p0 = pulses;
    step(1);
    check("sat_val", int'(params[2*PW +: PW]), VMAX);
    check("sat_no_pulse", pulses - p0, 0);
    press(0);

    // cancel vs commit on register 1 starting at 10
    goto_sel(1);
    press(0);
    for (int k = 0; k < 10; k++) step(1);
    press(0);
    press(0);
    for (int k = 0; k < 4; k++) step(1);
    check("cancel_pre", int'(params[1*PW +: PW]), 14);
    p0 = pulses;
    press(1);
    check("cancel_val", int'(params[1*PW +: PW]), 10);
    check("cancel_pulses", pulses - p0, 1);
    check("cancel_editing", int'(editing), 0);
    press(0);
    for (int k = 0; k < 4; k++) step(1);
    press(0);
    check("commit_val", int'(params[1*PW +: PW]), 14);

    // timeout: editing falls exactly TO cycles after the last step
    press(0);
    step(1);
    n = 0;
    while (editing && n < 3 * TO) begin
      idle(1);
      n++;
    end
    check("timeout_cycles", n, TO);
    check("timeout_val", int'(params[1*PW +: PW]), 15);

    // collision: press wins over step
    p0 = int'(sel);
    cycle(1, 1, 1, 0);
    check("coll_editing", int'(editing), 1);
    check("coll_sel", int'(sel), p0);
    press(0);

    // long press in BROWSE on value 7
    goto_sel(0);
    press(0);
    for (int k = 0; k < 7; k++) step(1);
    press(0);
    p0 = pulses;
    press(1);
    check("long_clr_val", int'(params[0 +: PW]), 0);
    check("long_clr_pulses", pulses - p0, 1);

    // random traffic with varying event density
    for (int blk = 0; blk < 60; blk++) begin
      int dens = $urandom_range(0, 3);
      for (int k = 0; k < 64; k++) begin
        int r = $urandom_range(0, 99);
        bit sv = (r < dens * 20);
        bit pv = ($urandom_range(0, 99) < dens * 3);
        cycle(sv, $urandom_range(0, 1) == 1, pv, $urandom_range(0, 1) == 1);
      end
    end

    // asynchronous reset mid-edit
    goto_sel(3);
    press(0);
    step(1); step(1);
    #2 rst = 1'b1;
    #1;
    check("arst_sel", int'(sel), 0);
    check("arst_editing", int'(editing), 0);
    check("arst_params", (params == '0) ? 1 : 0, 1);
    check("arst_upd_valid", int'(upd_valid), 0);
    check("arst_upd_idx", int'(upd_idx), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    press(0);
    step(1);
    press(0);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
